// File: rtl/pfd_loop_filter.sv
// Digital charge pump and PI loop filter: measures PFD up/dn pulse widths in clk
// cycles and turns their difference into a DCO control word, with lock/saturation flags.
module pfd_loop_filter #(
  parameter int CNT_W      = 8,
  parameter int CTRL_W     = 16,
  parameter int KP_SHIFT   = 6,
  parameter int KI_SHIFT   = 2,
  parameter int INIT_CTRL  = 32768,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up,
  input  logic                    dn,
  output logic [CTRL_W-1:0]       ctrl_word,
  output logic                    ctrl_valid,
  output logic signed [CNT_W:0]   phase_err,
  output logic                    sat,
  output logic                    locked
);

  localparam int SUM_W  = CTRL_W + CNT_W + 2;
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic signed [SUM_W-1:0] CTRL_MAX = {{(SUM_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};
  localparam logic [CTRL_W-1:0]       CTRL_INIT = CTRL_W'(INIT_CTRL);

  typedef enum logic [1:0] {IDLE, MEASURE, UPDATE, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     up_meta_q, up_meta_d, up_s_q, up_s_d;
  logic                     dn_meta_q, dn_meta_d, dn_s_q, dn_s_d;
  logic [CNT_W-1:0]         up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
  logic                     forced_q, forced_d;
  logic [CTRL_W-1:0]        integ_q, integ_d, ctrl_q, ctrl_d;
  logic                     valid_q, valid_d;
  logic signed [CNT_W:0]    perr_q, perr_d;
  logic                     sat_q, sat_d;
  logic [LOCK_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic                     locked_q, locked_d;

  logic signed [CNT_W:0]    err;
  logic signed [SUM_W-1:0]  err_w, integ_sum, ctrl_sum;
  logic [CTRL_W-1:0]        integ_n, ctrl_n;
  logic                     integ_clip, ctrl_clip, up_ovf, dn_ovf, in_tol;

  function automatic logic [CTRL_W-1:0] clamp_ctrl(input logic signed [SUM_W-1:0] v);
    if (v < 0)             return '0;
    else if (v > CTRL_MAX) return '1;
    else                   return v[CTRL_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
    return (v < 0) || (v > CTRL_MAX);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    up_meta_d  = up;
    up_s_d     = up_meta_q;
    dn_meta_d  = dn;
    dn_s_d     = dn_meta_q;
    state_d    = state_q;
    up_cnt_d   = up_cnt_q;
    dn_cnt_d   = dn_cnt_q;
    forced_d   = forced_q;
    integ_d    = integ_q;
    ctrl_d     = ctrl_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    sat_d      = sat_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;

    // Full-width signed intermediates keep the PI sums from wrapping before the clamp.
    err        = $signed({1'b0, up_cnt_q}) - $signed({1'b0, dn_cnt_q});
    err_w      = {{(SUM_W-CNT_W-1){err[CNT_W]}}, err};
    integ_sum  = $signed({{(SUM_W-CTRL_W){1'b0}}, integ_q}) + (err_w <<< KI_SHIFT);
    integ_n    = clamp_ctrl(integ_sum);
    ctrl_sum   = $signed({{(SUM_W-CTRL_W){1'b0}}, integ_n}) + (err_w <<< KP_SHIFT);
    ctrl_n     = clamp_ctrl(ctrl_sum);
    integ_clip = out_of_range(integ_sum);
    ctrl_clip  = out_of_range(ctrl_sum);
    in_tol     = (err >= -LOCK_TOL) && (err <= LOCK_TOL);
    up_ovf     = up_s_q && (up_cnt_q == CNT_MAX);
    dn_ovf     = dn_s_q && (dn_cnt_q == CNT_MAX);

    unique case (state_q)
      IDLE: begin
        if (up_s_q || dn_s_q) begin
          up_cnt_d = {{(CNT_W-1){1'b0}}, up_s_q};
          dn_cnt_d = {{(CNT_W-1){1'b0}}, dn_s_q};
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        if (!up_s_q && !dn_s_q) begin
          state_d = UPDATE;
        end else begin
          if (up_s_q && !up_ovf) up_cnt_d = up_cnt_q + CNT_W'(1);
          if (dn_s_q && !dn_ovf) dn_cnt_d = dn_cnt_q + CNT_W'(1);
          if (up_ovf || dn_ovf) begin
            forced_d = 1'b1;
            state_d  = UPDATE;
          end
        end
      end
      UPDATE: begin
        integ_d  = integ_n;
        ctrl_d   = ctrl_n;
        perr_d   = err;
        sat_d    = integ_clip || ctrl_clip;
        valid_d  = 1'b1;
        if (!in_tol)                               lock_cnt_d = '0;
        else if (lock_cnt_q != LOCK_W'(LOCK_COUNT)) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        locked_d = (lock_cnt_d == LOCK_W'(LOCK_COUNT));
        up_cnt_d = '0;
        dn_cnt_d = '0;
        forced_d = 1'b0;
        // A forced update must not re-measure the still-high pulse.
        state_d  = forced_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!up_s_q && !dn_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; all flops, synchronizers included, clear on the
      // edge, which also discards any measurement in progress.
      state_q    <= IDLE;
      up_meta_q  <= 1'b0;
      up_s_q     <= 1'b0;
      dn_meta_q  <= 1'b0;
      dn_s_q     <= 1'b0;
      up_cnt_q   <= '0;
      dn_cnt_q   <= '0;
      forced_q   <= 1'b0;
      integ_q    <= CTRL_INIT;
      ctrl_q     <= CTRL_INIT;
      valid_q    <= 1'b0;
      perr_q     <= '0;
      sat_q      <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_meta_q  <= up_meta_d;
      up_s_q     <= up_s_d;
      dn_meta_q  <= dn_meta_d;
      dn_s_q     <= dn_s_d;
      up_cnt_q   <= up_cnt_d;
      dn_cnt_q   <= dn_cnt_d;
      forced_q   <= forced_d;
      integ_q    <= integ_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      sat_q      <= sat_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign ctrl_word  = ctrl_q;
  assign ctrl_valid = valid_q;
  assign phase_err  = perr_q;
  assign sat        = sat_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Bench for pfd_loop_filter: random and directed up/dn pulse pairs, checked every cycle
// against a pulse-width / PI arithmetic model, plus a high-INIT instance for the stuck-pulse case.
`timescale 1ns/1ps
module tb_pfd_loop_filter;

  localparam int MAXC = 65535;

  typedef struct {
    longint due;
    int     err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, dn = 1'b0, up2 = 1'b0, dn2 = 1'b0;
  logic [15:0] ctrl_word, ctrl_word2;
  logic        ctrl_valid, ctrl_valid2;
  logic signed [8:0] phase_err, phase_err2;
  logic        sat, sat2, locked, locked2;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  logic   rst_q    = 1'b1;
  exp_t   exp_q[$];

  int   m_integ = 32768, m_ctrl = 32768, m_perr = 0, m_sat = 0, m_run = 0, m_locked = 0;
  exp_t cur;
  logic exp_v;
  int   v2_cnt = 0;
  longint v2_cyc = -1;

  pfd_loop_filter dut (
    .clk(clk), .rst(rst), .up(up), .dn(dn),
    .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid), .phase_err(phase_err),
    .sat(sat), .locked(locked)
  );

  pfd_loop_filter #(.INIT_CTRL(65000)) dut_hi (
    .clk(clk), .rst(rst), .up(up2), .dn(dn2),
    .ctrl_word(ctrl_word2), .ctrl_valid(ctrl_valid2), .phase_err(phase_err2),
    .sat(sat2), .locked(locked2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : (v > MAXC) ? MAXC : v;
  endfunction

  // Reference: each completed measurement contributes err = up width - dn width.
  always @(negedge clk) begin
    if (rst_q) begin
      m_integ = 32768; m_ctrl = 32768; m_perr = 0; m_sat = 0; m_run = 0; m_locked = 0;
      exp_q.delete();
    end
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("ctrl_valid", ctrl_valid, exp_v);
    if (exp_v) begin
      int raw_i, raw_c;
      cur     = exp_q.pop_front();
      raw_i   = m_integ + cur.err * 4;
      m_integ = clampc(raw_i);
      raw_c   = m_integ + cur.err * 64;
      m_ctrl  = clampc(raw_c);
      m_sat   = (raw_i != m_integ) || (raw_c != m_ctrl);
      m_perr  = cur.err;
      m_run   = (cur.err >= -2 && cur.err <= 2) ? ((m_run < 16) ? m_run + 1 : 16) : 0;
      m_locked = (m_run == 16);
    end
    check("ctrl_word", ctrl_word, m_ctrl);
    check("phase_err", phase_err, m_perr);
    check("sat", sat, m_sat);
    check("locked", locked, m_locked);
  end

  always @(negedge clk) begin
    if (ctrl_valid2) begin
      v2_cnt++;
      if (v2_cnt == 1) v2_cyc = cyc;
    end
  end

  // Pulse A (width wa) starts at 0, pulse B (width wb) at s <= wa, so they form one measurement.
  task automatic pulse_pair(input bit a_is_up, input int wa, input int s, input int wb,
                            input int gap);
    int   last_t;
    logic a, b;
    exp_t e;
    last_t = (wa > s + wb) ? wa : s + wb;
    for (int t = 0; t <= last_t; t++) begin
      @(negedge clk);
      a  = (t < wa);
      b  = (t >= s) && (t < s + wb);
      up = a_is_up ? a : b;
      dn = a_is_up ? b : a;
      if (t == last_t) begin
        e.due = cyc + 4;
        e.err = a_is_up ? (wa - wb) : (wb - wa);
        exp_q.push_back(e);
      end
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse(input bit is_up, input int w);
    pulse_pair(is_up, w, 0, 0, 8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    pulse(1'b1, 5);
    check("lit_up5_ctrl", ctrl_word, 33108);
    check("lit_up5_err", phase_err, 5);
    check("lit_up5_sat", sat, 0);

    do_reset();
    pulse(1'b0, 3);
    check("lit_dn3_ctrl", ctrl_word, 32564);
    check("lit_dn3_err", phase_err, -3);
    pulse(1'b0, 3);
    check("lit_dn3b_ctrl", ctrl_word, 32552);

    do_reset();
    pulse_pair(1'b1, 4, 0, 4, 8);
    check("lit_overlap_ctrl", ctrl_word, 32768);
    check("lit_overlap_err", phase_err, 0);

    // Reset in the middle of a 10-cycle up pulse: no update may come out of it.
    @(negedge clk); up = 1'b1;
    repeat (4) @(negedge clk); rst = 1'b1;
    repeat (5) @(negedge clk); up = 1'b0;
    repeat (5) @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    pulse(1'b1, 4);
    check("lit_after_rst_err", phase_err, 4);
    check("lit_after_rst_ctrl", ctrl_word, 33040);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      pulse(i[0] == 1'b0, 1);
      if (i == 14) check("lit_lock_15", locked, 0);
    end
    check("lit_lock_16", locked, 1);
    pulse(1'b1, 5);
    check("lit_lock_lost", locked, 0);

    for (int i = 0; i < 60; i++) begin
      int wa, wb, s;
      wa = $urandom_range(40, 1);
      wb = $urandom_range(40, 0);
      s  = $urandom_range(wa, 0);
      pulse_pair($urandom_range(1, 0) == 1, wa, s, wb, $urandom_range(12, 6));
    end

    do_reset();
    for (int i = 0; i < 36; i++) pulse(1'b0, 250);
    check("lit_low_clamp_ctrl", ctrl_word, 0);
    check("lit_low_clamp_sat", sat, 1);
    pulse(1'b1, 250);
    check("lit_recover_ctrl", ctrl_word, 17000);
    check("lit_recover_sat", sat, 0);

    // Stuck up pulse on the high-INIT instance: one forced update, then drain.
    do_reset();
    v2_cnt = 0;
    @(negedge clk); up2 = 1'b1; c0 = cyc;
    repeat (299) @(negedge clk);
    check("hi_single_strobe_held", v2_cnt, 1);
    up2 = 1'b0;
    repeat (20) @(negedge clk);
    check("hi_strobe_count", v2_cnt, 1);
    check("hi_strobe_cycle", v2_cyc, c0 + 259);
    check("hi_ctrl", ctrl_word2, 65535);
    check("hi_sat", sat2, 1);
    check("hi_err", phase_err2, 255);
    @(negedge clk); up2 = 1'b1;
    repeat (3) @(negedge clk); up2 = 1'b0;
    repeat (12) @(negedge clk);
    check("hi_second_count", v2_cnt, 2);
    check("hi_second_err", phase_err2, 3);
    check("hi_second_ctrl", ctrl_word2, 65535);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
